tx_focus_ch: RTL

TX_FOCUS_CH -- requirements
Module: tx_focus_ch

---
 rtl/tx_focus_ch_pkg.sv | 18 +
 rtl/tx_focus_ch_lut.sv | 27 ++
 rtl/tx_focus_ch.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/tx_focus_ch_pkg.sv
// Shared DBF channel header: default widths and the transmit FSM state encoding.
package tx_focus_ch_pkg;

   localparam int DBF_ADDR_WD = 7;
   localparam int DBF_DLY_WD  = 16;
   localparam int DBF_HP_WD   = 8;
   localparam int DBF_NC_WD   = 4;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_DELAY = 3'd2,
      ST_POS   = 3'd3,
      ST_NEG   = 3'd4,
      ST_FIN   = 3'd5
   } tx_state_t;

endpackage

// File: rtl/tx_focus_ch_lut.sv
// Per-line focal delay table: synchronous write, combinational read.
// Combinational read means a write landing on the same edge that captures
// the read still hands back the old word.
module tx_delay_lut #(
   parameter int ADDR_WD = 7,
   parameter int DLY_WD  = 16
) (
   input  logic               clk,
   input  logic               we,
   input  logic [ADDR_WD-1:0] waddr,
   input  logic [DLY_WD-1:0]  wdata,
   input  logic [ADDR_WD-1:0] raddr,
   output logic [DLY_WD-1:0]  rdata
);

   logic [DLY_WD-1:0] mem [2**ADDR_WD];

   // Table write; contents deliberately survive reset
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/tx_focus_ch.sv
// Transmit focusing channel: waits the per-line focal delay from the LUT,
// then emits n_cycles bipolar pulses of half_period cycles per half.
module tx_focus_ch
   import tx_focus_ch_pkg::*;
#(
   parameter int ADDR_WD = DBF_ADDR_WD,
   parameter int DLY_WD  = DBF_DLY_WD,
   parameter int HP_WD   = DBF_HP_WD,
   parameter int NC_WD   = DBF_NC_WD
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [ADDR_WD-1:0] lut_addr,
   input  logic [DLY_WD-1:0]  lut_din,
   input  logic               lut_we,
   input  logic [ADDR_WD-1:0] line_sel,
   input  logic               fire,
   input  logic               abort,
   input  logic [HP_WD-1:0]   half_period,
   input  logic [NC_WD-1:0]   n_cycles,
   output logic               tx_p,
   output logic               tx_n,
   output logic               busy,
   output logic               done
);

   tx_state_t          state;
   logic [ADDR_WD-1:0] line_q;
   logic [HP_WD-1:0]   hp_q;
   logic [NC_WD-1:0]   nc_q;
   logic [DLY_WD-1:0]  dly_cnt;
   logic [HP_WD-1:0]   hp_cnt;
   logic [NC_WD-1:0]   nc_cnt;
   logic [DLY_WD-1:0]  lut_rd;

   tx_delay_lut #(
      .ADDR_WD (ADDR_WD),
      .DLY_WD  (DLY_WD)
   ) u_lut (
      .clk   (clk),
      .we    (lut_we),
      .waddr (lut_addr),
      .wdata (lut_din),
      .raddr (line_q),
      .rdata (lut_rd)
   );

   // Transmit sequencer; counters load their full value and count down to 1,
   // so maximum-width settings finish exactly without wrapping
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         tx_p    <= 1'b0;
         tx_n    <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         line_q  <= '0;
         hp_q    <= '0;
         nc_q    <= '0;
         dly_cnt <= '0;
         hp_cnt  <= '0;
         nc_cnt  <= '0;
      end else begin
         done <= 1'b0;
         if (abort && (state != ST_IDLE)) begin
            state <= ST_IDLE;
            tx_p  <= 1'b0;
            tx_n  <= 1'b0;
            busy  <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (fire && !abort) begin
                     line_q <= line_sel;
                     hp_q   <= (half_period == '0) ? HP_WD'(1) : half_period;
                     nc_q   <= n_cycles;
                     busy   <= 1'b1;
                     state  <= ST_FETCH;
                  end
               end
               ST_FETCH: begin
                  dly_cnt <= lut_rd;
                  nc_cnt  <= nc_q;
                  if (lut_rd != '0) begin
                     state <= ST_DELAY;
                  end else if (nc_q != '0) begin
                     state  <= ST_POS;
                     tx_p   <= 1'b1;
                     hp_cnt <= hp_q;
                  end else begin
                     state <= ST_FIN;
                     done  <= 1'b1;
                  end
               end
               ST_DELAY: begin
                  if (dly_cnt == DLY_WD'(1)) begin
                     dly_cnt <= '0;
                     if (nc_cnt != '0) begin
                        state  <= ST_POS;
                        tx_p   <= 1'b1;
                        hp_cnt <= hp_q;
                     end else begin
                        state <= ST_FIN;
                        done  <= 1'b1;
                     end
                  end else begin
                     dly_cnt <= dly_cnt - DLY_WD'(1);
                  end
               end
               ST_POS: begin
                  if (hp_cnt == HP_WD'(1)) begin
                     state  <= ST_NEG;
                     tx_p   <= 1'b0;
                     tx_n   <= 1'b1;
                     hp_cnt <= hp_q;
                  end else begin
                     hp_cnt <= hp_cnt - HP_WD'(1);
                  end
               end
               ST_NEG: begin
                  if (hp_cnt == HP_WD'(1)) begin
                     tx_n   <= 1'b0;
                     nc_cnt <= nc_cnt - NC_WD'(1);
                     if (nc_cnt == NC_WD'(1)) begin
                        state <= ST_FIN;
                        done  <= 1'b1;
                     end else begin
                        state  <= ST_POS;
                        tx_p   <= 1'b1;
                        hp_cnt <= hp_q;
                     end
                  end else begin
                     hp_cnt <= hp_cnt - HP_WD'(1);
                  end
               end
               ST_FIN: begin
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end
               default: begin
                  state <= ST_IDLE;
                  tx_p  <= 1'b0;
                  tx_n  <= 1'b0;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
